val2_shift_unit: RTL and testbench

Parametrised, multi-cycle successor to the combinational operand-2 generator in the EXE stage. It produces the ARM data-processing/memory second operand plus the shifter carry-out. It adds register-specified shift amounts (Rs[7:0]), RRX, full ARM carry semantics and a configurable shift step per cycle. A valid/ready handshake on both sides lets the pipeline stall on long shifts instead of lengthening the critical path.

---
 rtl/val2_shift_unit_pkg.sv | 21 ++
 rtl/val2_shift_unit_shift_step.sv | 59 +++++
 rtl/val2_shift_unit.sv | 160 ++++++++++++++++
 tb/tb_val2_shift_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/val2_shift_unit_pkg.sv
// Shared encodings for the EXE-stage operand-2 shifter: request modes,
// ARM shift types and the FSM state type.
package val2_pkg;

    localparam logic [1:0] MODE_MEM     = 2'd0;
    localparam logic [1:0] MODE_IMM     = 2'd1;
    localparam logic [1:0] MODE_REG_IMM = 2'd2;
    localparam logic [1:0] MODE_REG_REG = 2'd3;

    localparam logic [1:0] LSL = 2'd0;
    localparam logic [1:0] LSR = 2'd1;
    localparam logic [1:0] ASR = 2'd2;
    localparam logic [1:0] ROR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/val2_shift_unit_shift_step.sv
// One bounded shift step (1..STEP positions) of a given ARM shift type,
// returning the shifted value and the last bit shifted out.
module shift_step
    import val2_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 6
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  amt,
    input  logic [1:0]        shift_type,
    input  logic              rrx,
    input  logic              c_in,
    output logic [DATA_W-1:0] data_out,
    output logic              carry_out
);

    localparam logic [AMT_W-1:0] W_A = AMT_W'(DATA_W);

    logic [DATA_W:0]   lsl_t;
    logic [DATA_W:0]   lsr_t;
    logic [DATA_W:0]   asr_t;
    logic [DATA_W-1:0] ror_v;

    always_comb begin
        // The extra bit on each side catches the last bit shifted out.
        lsl_t = {1'b0, data_in} << amt;
        lsr_t = {data_in, 1'b0} >> amt;
        asr_t = $signed({data_in, 1'b0}) >>> amt;
        ror_v = (data_in >> amt) | (data_in << (W_A - amt));

        data_out  = data_in;
        carry_out = c_in;
        if (rrx) begin
            data_out  = {c_in, data_in[DATA_W-1:1]};
            carry_out = data_in[0];
        end else begin
            case (shift_type)
                LSL: begin
                    data_out  = lsl_t[DATA_W-1:0];
                    carry_out = lsl_t[DATA_W];
                end
                LSR: begin
                    data_out  = lsr_t[DATA_W:1];
                    carry_out = lsr_t[0];
                end
                ASR: begin
                    data_out  = asr_t[DATA_W:1];
                    carry_out = asr_t[0];
                end
                default: begin
                    data_out  = ror_v;
                    carry_out = ror_v[DATA_W-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/val2_shift_unit.sv
// Multi-cycle ARM operand-2 generator: captures a request, shifts it STEP
// bits per cycle through shift_step, and holds the result until consumed.
module val2_shift_unit
    import val2_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int STEP    = 8,
    parameter int SHAMT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [11:0]        shifter_operand,
    input  logic [DATA_W-1:0]  val_rm,
    input  logic [SHAMT_W-1:0] val_rs,
    input  logic               c_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  val2,
    output logic               carry_out,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer on either side happens on a rising clk edge where
    // valid and ready are both high; the result is held stable while
    // out_valid=1 and out_ready=0, and flush overrides both sides.

    localparam int               AMT_W     = $clog2(DATA_W + 2);
    localparam logic [AMT_W-1:0] STEP_A    = AMT_W'(STEP);
    localparam logic [31:0]      LIM_SHIFT = 32'(DATA_W + 1);
    localparam logic [31:0]      LIM_ASR   = 32'(DATA_W);
    localparam logic [31:0]      ROT_MASK  = 32'(DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic              carry_q;
    logic [AMT_W-1:0]  rem_q;
    logic [1:0]        type_q;
    logic              rrx_q;

    logic [1:0]        sh_type;
    logic [31:0]       amt_raw;
    logic [31:0]       ror_amt;
    logic [DATA_W-1:0] init_data;
    logic              init_carry;
    logic [AMT_W-1:0]  init_rem;
    logic [1:0]        init_type;
    logic              init_rrx;

    logic [AMT_W-1:0]  step_amt;
    logic [DATA_W-1:0] step_data;
    logic              step_carry;

    assign in_ready  = rst && (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign val2      = data_q;
    assign carry_out = carry_q;
    assign dbg_state = state_q;

    // Decode the request into a starting value, carry and total shift amount.
    always_comb begin
        sh_type    = shifter_operand[6:5];
        amt_raw    = (mode == MODE_REG_REG) ? 32'(val_rs) : 32'(shifter_operand[11:7]);
        ror_amt    = amt_raw & ROT_MASK;
        init_data  = val_rm;
        init_carry = c_in;
        init_rem   = '0;
        init_type  = sh_type;
        init_rrx   = 1'b0;
        case (mode)
            MODE_MEM: begin
                init_data = {{(DATA_W-12){shifter_operand[11]}}, shifter_operand};
            end
            MODE_IMM: begin
                init_data = {{(DATA_W-8){1'b0}}, shifter_operand[7:0]};
                init_type = ROR;
                init_rem  = AMT_W'({shifter_operand[11:8], 1'b0});
            end
            default: begin
                if (amt_raw == 32'd0) begin
                    // Immediate-amount #0 encodings other than LSL mean something else.
                    if (mode == MODE_REG_IMM) begin
                        case (sh_type)
                            LSR, ASR: init_rem = AMT_W'(DATA_W);
                            ROR: begin
                                init_rrx = 1'b1;
                                init_rem = AMT_W'(1);
                            end
                            default: init_rem = '0;
                        endcase
                    end
                end else begin
                    case (sh_type)
                        LSL, LSR: init_rem = (amt_raw > LIM_SHIFT) ? AMT_W'(LIM_SHIFT) : AMT_W'(amt_raw);
                        ASR:      init_rem = (amt_raw > LIM_ASR) ? AMT_W'(LIM_ASR) : AMT_W'(amt_raw);
                        default: begin
                            init_rem = AMT_W'(ror_amt);
                            if (ror_amt == 32'd0) init_carry = val_rm[DATA_W-1];
                        end
                    endcase
                end
            end
        endcase
    end

    assign step_amt = (rem_q > STEP_A) ? STEP_A : rem_q;

    shift_step #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shift_step (
        .data_in    (data_q),
        .amt        (step_amt),
        .shift_type (type_q),
        .rrx        (rrx_q),
        .c_in       (carry_q),
        .data_out   (step_data),
        .carry_out  (step_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            rem_q   <= '0;
            type_q  <= LSL;
            rrx_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q  <= init_data;
                        carry_q <= init_carry;
                        rem_q   <= init_rem;
                        type_q  <= init_type;
                        rrx_q   <= init_rrx;
                        state_q <= (init_rem == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_q  <= step_data;
                    carry_q <= step_carry;
                    rem_q   <= rem_q - step_amt;
                    if (rem_q == step_amt) state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_val2_shift_unit.sv
// Directed bench for val2_shift_unit: table of hand-computed vectors plus
// stall, flush, reset-abort and back-to-back scenarios.
module tb_val2_shift_unit;
    import val2_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = 2'd0;
    logic [11:0] shifter_operand = 12'd0;
    logic [31:0] val_rm = 32'd0;
    logic [7:0]  val_rs = 8'd0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] val2;
    logic        carry_out;
    logic [1:0]  dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [1:0]  m;
        logic [11:0] op;
        logic [31:0] rm;
        logic [7:0]  rs;
        logic        cin;
        logic [31:0] exp_v;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    vec_t tbl[15];

    val2_shift_unit #(.DATA_W(32), .STEP(8), .SHAMT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .mode            (mode),
        .shifter_operand (shifter_operand),
        .val_rm          (val_rm),
        .val_rs          (val_rs),
        .c_in            (c_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .val2            (val2),
        .carry_out       (carry_out),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (vectors=%0d)", vec_cnt);
        $fatal(1);
    end

    // Present one request; returns 1 ns after the accept edge with inputs scrambled.
    task automatic accept_req(input logic [1:0] m, input logic [11:0] op,
                              input logic [31:0] rm, input logic [7:0] rs, input logic cin);
        @(negedge clk);
        mode = m; shifter_operand = op; val_rm = rm; val_rs = rs; c_in = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode = 2'($urandom); shifter_operand = 12'($urandom);
        val_rm = $urandom; val_rs = 8'($urandom); c_in = ~cin;
    endtask

    // Counts edges from the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vec_cnt++; if (val2 !== 32'd0) begin err_cnt++; $display("FAIL reset_val2: got %h want 00000000", val2); end
        vec_cnt++; if (carry_out !== 1'b0) begin err_cnt++; $display("FAIL reset_carry: got %b want 0", carry_out); end
        vec_cnt++; if (dbg_state !== IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_vectors();
        int lat;
        tbl[0]  = '{MODE_MEM,     12'h804, 32'h0000_0000, 8'd0,  1'b1, 32'hFFFF_F804, 1'b1, 1};
        tbl[1]  = '{MODE_IMM,     12'h4FF, 32'h0000_0000, 8'd0,  1'b0, 32'hFF00_0000, 1'b1, 2};
        tbl[2]  = '{MODE_REG_REG, 12'h000, 32'h0000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 5};
        tbl[3]  = '{MODE_REG_REG, 12'h000, 32'h0000_0001, 8'd33, 1'b0, 32'h0000_0000, 1'b0, 6};
        tbl[4]  = '{MODE_REG_REG, 12'h000, 32'h0000_0001, 8'd0,  1'b1, 32'h0000_0001, 1'b1, 1};
        tbl[5]  = '{MODE_REG_IMM, 12'h060, 32'h0000_0003, 8'd0,  1'b1, 32'h8000_0001, 1'b1, 2};
        tbl[6]  = '{MODE_REG_REG, 12'h060, 32'h8000_0001, 8'd32, 1'b0, 32'h8000_0001, 1'b1, 1};
        tbl[7]  = '{MODE_REG_REG, 12'h060, 32'h0000_000F, 8'd4,  1'b0, 32'hF000_0000, 1'b1, 2};
        tbl[8]  = '{MODE_REG_REG, 12'h040, 32'h7FFF_FFFF, 8'd40, 1'b1, 32'h0000_0000, 1'b0, 5};
        tbl[9]  = '{MODE_REG_IMM, 12'h020, 32'h8000_0000, 8'd0,  1'b0, 32'h0000_0000, 1'b1, 5};
        tbl[10] = '{MODE_REG_IMM, 12'h200, 32'hF000_0001, 8'd0,  1'b0, 32'h0000_0010, 1'b1, 2};
        tbl[11] = '{MODE_REG_REG, 12'h020, 32'h0000_0800, 8'd12, 1'b0, 32'h0000_0000, 1'b1, 3};
        tbl[12] = '{MODE_IMM,     12'h0AB, 32'h0000_0000, 8'd0,  1'b1, 32'h0000_00AB, 1'b1, 1};
        tbl[13] = '{MODE_REG_REG, 12'h040, 32'h8000_0000, 8'd4,  1'b1, 32'hF800_0000, 1'b0, 2};
        tbl[14] = '{MODE_REG_IMM, 12'h000, 32'h1234_5678, 8'd0,  1'b1, 32'h1234_5678, 1'b1, 1};
        for (int i = 0; i < 15; i++) begin
            accept_req(tbl[i].m, tbl[i].op, tbl[i].rm, tbl[i].rs, tbl[i].cin);
            wait_valid(lat);
            vec_cnt++; if (lat !== tbl[i].exp_lat) begin err_cnt++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, tbl[i].exp_lat); end
            vec_cnt++; if (val2 !== tbl[i].exp_v) begin err_cnt++; $display("FAIL vec%0d_val2: got %h want %h", i, val2, tbl[i].exp_v); end
            vec_cnt++; if (carry_out !== tbl[i].exp_c) begin err_cnt++; $display("FAIL vec%0d_carry: got %b want %b", i, carry_out, tbl[i].exp_c); end
            consume();
            vec_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL vec%0d_release: got valid=%b ready=%b want 0/1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_hold();
        int lat;
        accept_req(MODE_REG_IMM, 12'h040, 32'h8000_0000, 8'd0, 1'b0);
        wait_valid(lat);
        vec_cnt++; if (lat !== 5) begin err_cnt++; $display("FAIL hold_latency: got %0d want 5", lat); end
        for (int i = 0; i < 5; i++) begin
            vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL hold%0d_valid: got %b want 1", i, out_valid); end
            vec_cnt++; if (val2 !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL hold%0d_val2: got %h want ffffffff", i, val2); end
            vec_cnt++; if (carry_out !== 1'b1) begin err_cnt++; $display("FAIL hold%0d_carry: got %b want 1", i, carry_out); end
            vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL hold%0d_in_ready: got %b want 0", i, in_ready); end
            @(posedge clk);
            #1;
        end
        consume();
        vec_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL hold_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_flush();
        logic seen;
        accept_req(MODE_REG_REG, 12'h020, 32'hFFFF_FFFF, 8'd20, 1'b0);
        @(posedge clk);
        #1;
        vec_cnt++; if (dbg_state !== SHIFT) begin err_cnt++; $display("FAIL flush_pre_state: got %0d want SHIFT", dbg_state); end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        vec_cnt++; if (dbg_state !== IDLE) begin err_cnt++; $display("FAIL flush_state: got %0d want IDLE", dbg_state); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL flush_no_emit: got out_valid seen=%b want 0", seen); end
    endtask

    task automatic test_reset_abort();
        logic seen;
        accept_req(MODE_REG_REG, 12'h020, 32'hFFFF_FFFF, 8'd20, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_abort_valid: got %b want 0", out_valid); end
        vec_cnt++; if (val2 !== 32'd0) begin err_cnt++; $display("FAIL rst_abort_val2: got %h want 00000000", val2); end
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_abort_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL rst_abort_no_emit: got out_valid seen=%b want 0", seen); end
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_abort_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mode = MODE_MEM; shifter_operand = 12'h123; c_in = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        mode = MODE_MEM; shifter_operand = 12'h9AB; c_in = 1'b1;
        vec_cnt++; if (out_valid !== 1'b1 || val2 !== 32'h0000_0123) begin err_cnt++; $display("FAIL b2b_first: got valid=%b val2=%h want 1/00000123", out_valid, val2); end
        @(posedge clk);
        #1;
        vec_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_gap: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vec_cnt++; if (out_valid !== 1'b1 || val2 !== 32'hFFFF_F9AB || carry_out !== 1'b1) begin err_cnt++; $display("FAIL b2b_second: got valid=%b val2=%h c=%b want 1/fffff9ab/1", out_valid, val2, carry_out); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_flush();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
